mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: one-hot FSM state,
// owner encoding and the latched request record.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    I_REQ  = 6'b000010,
    I_RESP = 6'b000100,
    D_WR   = 6'b001000,
    D_RD   = 6'b010000,
    D_RESP = 6'b100000
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  function automatic logic [31:0] cnt_inc(input logic [31:0] cnt, input logic en);
    return cnt + {31'd0, en};
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-requester pick logic producing a one-hot grant {data, inst}.
// With RR_EN clear the data requester always wins a tie.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic       req_i,
  input  logic       req_d,
  input  owner_t     last_own,
  output logic [1:0] gnt
);

  logic prefer_d;

  always_comb begin
    // On a tie, round-robin hands the grant to whoever did not win last time.
    prefer_d = RR_EN ? (last_own == OWN_I) : 1'b1;
    gnt      = 2'b00;
    if (req_d && (prefer_d || !req_i)) begin
      gnt[1] = 1'b1;
    end else if (req_i) begin
      gnt[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// Define ARB_RR_EN for round-robin tie-breaking; default is data-over-instruction.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_addr,
  input  logic        d_wen,
  input  logic        d_ren,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_req_ready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [31:0] m_addr,
  output logic        m_wen,
  output logic        m_ren,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_req_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] gnt_i_cnt,
  output logic [31:0] gnt_d_cnt
);

  state_t      state_q, state_d;
  req_t        lat_q, lat_d;
  logic [31:0] gnt_i_cnt_q, gnt_i_cnt_d;
  logic [31:0] gnt_d_cnt_q, gnt_d_cnt_d;
  logic        d_req_valid;
  logic [1:0]  gnt;
  owner_t      rr_last;

  assign d_req_valid = d_wen | d_ren;

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  owner_t rr_last_q, rr_last_d;

  assign rr_last = rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == IDLE && !rst) begin
      if (gnt[1]) begin
        rr_last_d = OWN_D;
      end else if (gnt[0]) begin
        rr_last_d = OWN_I;
      end
    end
  end

  // Reset value lets the first contended grant go to data, the same order
  // the fixed-priority build uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= OWN_I;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam bit RR_EN = 1'b0;
  assign rr_last = OWN_I;
`endif

  arb_pick #(
    .RR_EN(RR_EN)
  ) u_arb_pick (
    .req_i   (i_req_valid),
    .req_d   (d_req_valid),
    .last_own(rr_last),
    .gnt     (gnt)
  );

  assign m_addr    = lat_q.addr;
  assign m_wdata   = lat_q.wdata;
  assign m_wstrb   = lat_q.wstrb;
  assign gnt_i_cnt = gnt_i_cnt_q;
  assign gnt_d_cnt = gnt_d_cnt_q;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    gnt_i_cnt_d = gnt_i_cnt_q;
    gnt_d_cnt_d = gnt_d_cnt_q;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rdata     = '0;
    i_rvalid    = 1'b0;
    d_rdata     = '0;
    d_rvalid    = 1'b0;
    m_wen       = 1'b0;
    m_ren       = 1'b0;
    m_rready    = 1'b0;

    case (state_q)
      IDLE: begin
        i_req_ready = gnt[0];
        d_req_ready = gnt[1];
        if (gnt[1]) begin
          lat_d.addr  = d_addr;
          lat_d.wdata = d_wdata;
          lat_d.wstrb = d_wstrb;
          gnt_d_cnt_d = cnt_inc(gnt_d_cnt_q, 1'b1);
          // A simultaneous write+read request is treated as a write.
          state_d     = d_wen ? D_WR : D_RD;
        end else if (gnt[0]) begin
          lat_d.addr  = i_addr;
          lat_d.wdata = '0;
          lat_d.wstrb = '0;
          gnt_i_cnt_d = cnt_inc(gnt_i_cnt_q, 1'b1);
          state_d     = I_REQ;
        end
      end
      I_REQ: begin
        m_ren = 1'b1;
        if (m_req_ready) state_d = I_RESP;
      end
      D_RD: begin
        m_ren = 1'b1;
        if (m_req_ready) state_d = D_RESP;
      end
      D_WR: begin
        m_wen = 1'b1;
        if (m_req_ready) state_d = IDLE;
      end
      I_RESP: begin
        i_rdata  = m_rdata;
        i_rvalid = m_rvalid;
        m_rready = i_rready;
        if (m_rvalid && i_rready) state_d = IDLE;
      end
      D_RESP: begin
        d_rdata  = m_rdata;
        d_rvalid = m_rvalid;
        m_rready = d_rready;
        if (m_rvalid && d_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshakes are suppressed while reset is held, so nothing in flight
    // can complete during the reset cycle.
    if (rst) begin
      i_req_ready = 1'b0;
      d_req_ready = 1'b0;
      i_rvalid    = 1'b0;
      d_rvalid    = 1'b0;
      m_wen       = 1'b0;
      m_ren       = 1'b0;
      m_rready    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      gnt_i_cnt_q <= '0;
      gnt_d_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      gnt_i_cnt_q <= gnt_i_cnt_d;
      gnt_d_cnt_q <= gnt_d_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the round-robin scenario is
// compiled in only when ARB_RR_EN is defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] d_addr;
  logic        d_wen;
  logic        d_ren;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rready;
  logic [31:0] m_addr;
  logic        m_wen;
  logic        m_ren;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] gnt_i_cnt;
  logic [31:0] gnt_d_cnt;

  int total;
  int bad;
  logic [31:0] exp_i_cnt;
  logic [31:0] exp_d_cnt;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_addr(d_addr), .d_wen(d_wen), .d_ren(d_ren), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_req_ready(d_req_ready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_req_ready(m_req_ready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .gnt_i_cnt(gnt_i_cnt), .gnt_d_cnt(gnt_d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({i_req_ready, d_req_ready, m_wen, m_ren, m_rready, i_rvalid, d_rvalid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {i_req_ready, d_req_ready, m_wen, m_ren, m_rready, i_rvalid, d_rvalid});
    end
    total++;
    if (gnt_i_cnt !== 32'd0 || gnt_d_cnt !== 32'd0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got i=%h d=%h st=%b want 0 0 %b",
               gnt_i_cnt, gnt_d_cnt, dut.state_q, IDLE);
    end
    rst = 1'b0;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    $display("txn reset: done");
  endtask

  task automatic test_priority();
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h100;
    d_ren = 1'b1; d_addr = 32'h200;
    m_req_ready = 1'b1; d_rready = 1'b1; i_rready = 1'b1;
    #1;
    total++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL prio_grant: got d,i=%b want 10", {d_req_ready, i_req_ready});
    end
    @(negedge clk);
    d_ren = 1'b0;
    #1;
    total++;
    if (m_ren !== 1'b1 || m_wen !== 1'b0 || m_addr !== 32'h200) begin
      bad++;
      $display("FAIL prio_d_mreq: got ren=%b wen=%b addr=%h want 1 0 00000200", m_ren, m_wen, m_addr);
    end
    total++;
    if (i_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL prio_busy: got i_req_ready=%b want 0", i_req_ready);
    end
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hCAFE0001;
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0001 || m_rready !== 1'b1 || i_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL prio_d_resp: got dv=%b dd=%h mr=%b iv=%b want 1 cafe0001 1 0",
               d_rvalid, d_rdata, m_rready, i_rvalid);
    end
    exp_d_cnt++;
    $display("txn data read addr=00000200 rdata=cafe0001");
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    total++;
    if (i_req_ready !== 1'b1 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL prio_i_grant: got ready=%b st=%b want 1 %b", i_req_ready, dut.state_q, IDLE);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    total++;
    if (m_ren !== 1'b1 || m_addr !== 32'h100) begin
      bad++;
      $display("FAIL prio_i_mreq: got ren=%b addr=%h want 1 00000100", m_ren, m_addr);
    end
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h13579BDF;
    #1;
    total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h13579BDF || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL prio_i_resp: got iv=%b id=%h dv=%b want 1 13579bdf 0", i_rvalid, i_rdata, d_rvalid);
    end
    exp_i_cnt++;
    $display("txn inst read addr=00000100 rdata=13579bdf");
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    total++;
    if (dut.state_q !== IDLE || gnt_i_cnt !== exp_i_cnt || gnt_d_cnt !== exp_d_cnt) begin
      bad++;
      $display("FAIL prio_end: got st=%b i=%0d d=%0d want %b %0d %0d",
               dut.state_q, gnt_i_cnt, gnt_d_cnt, IDLE, exp_i_cnt, exp_d_cnt);
    end
  endtask

  task automatic test_write_stall();
    @(negedge clk);
    m_req_ready = 1'b0;
    d_wen = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_wstrb = 4'h3;
    #1;
    total++;
    if (d_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_grant: got d_req_ready=%b want 1", d_req_ready);
    end
    exp_d_cnt++;
    @(negedge clk);
    d_wen = 1'b0; d_addr = 32'hFFFFFFF0; d_wdata = 32'h0; d_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m_req_ready = 1'b1;
      #1;
      total++;
      if (m_wen !== 1'b1 || m_ren !== 1'b0 || m_addr !== 32'h10 ||
          m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'h3) begin
        bad++;
        $display("FAIL wr_hold%0d: got wen=%b ren=%b a=%h d=%h s=%h want 1 0 00000010 deadbeef 3",
                 k, m_wen, m_ren, m_addr, m_wdata, m_wstrb);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (dut.state_q !== IDLE || m_wen !== 1'b0) begin
      bad++;
      $display("FAIL wr_done: got st=%b wen=%b want %b 0", dut.state_q, m_wen, IDLE);
    end
    $display("txn data write addr=00000010 wdata=deadbeef wstrb=3");
    d_wen = 1'b1; d_ren = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A5A5A5A; d_wstrb = 4'hF;
    #1;
    total++;
    if (d_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrrd_grant: got d_req_ready=%b want 1", d_req_ready);
    end
    exp_d_cnt++;
    @(negedge clk);
    d_wen = 1'b0; d_ren = 1'b0;
    #1;
    total++;
    if (m_wen !== 1'b1 || m_ren !== 1'b0 || m_addr !== 32'h20) begin
      bad++;
      $display("FAIL wrrd_is_write: got wen=%b ren=%b addr=%h want 1 0 00000020", m_wen, m_ren, m_addr);
    end
    @(negedge clk);
    #1;
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL wrrd_done: got st=%b want %b", dut.state_q, IDLE);
    end
    $display("txn data write+read addr=00000020 treated as write");
    m_req_ready = 1'b0;
  endtask

  task automatic test_inst_backpressure();
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h40; i_rready = 1'b0; d_rready = 1'b1; m_req_ready = 1'b1;
    #1;
    total++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL bp_grant: got i,d=%b want 10", {i_req_ready, d_req_ready});
    end
    exp_i_cnt++;
    @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    total++;
    if (m_ren !== 1'b1 || m_addr !== 32'h40) begin
      bad++;
      $display("FAIL bp_mreq: got ren=%b addr=%h want 1 00000040", m_ren, m_addr);
    end
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h00000013;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'h13 || m_rready !== 1'b0 ||
          d_rvalid !== 1'b0 || dut.state_q !== I_RESP) begin
        bad++;
        $display("FAIL bp_hold%0d: got iv=%b id=%h mr=%b dv=%b st=%b want 1 00000013 0 0 %b",
                 k, i_rvalid, i_rdata, m_rready, d_rvalid, dut.state_q, I_RESP);
      end
      @(negedge clk);
    end
    i_rready = 1'b1;
    #1;
    total++;
    if (m_rready !== 1'b1 || i_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: got mr=%b iv=%b want 1 1", m_rready, i_rvalid);
    end
    @(negedge clk);
    #1;
    total++;
    if (dut.state_q !== IDLE || i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_rready !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle_ignore: got st=%b iv=%b dv=%b mr=%b want %b 0 0 0",
               dut.state_q, i_rvalid, d_rvalid, m_rready, IDLE);
    end
    @(negedge clk);
    #1;
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL bp_stay_idle: got st=%b want %b", dut.state_q, IDLE);
    end
    m_rvalid = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
    $display("txn inst read addr=00000040 rdata=00000013 after 2-cycle stall");
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    i_req_valid = 1'b1; i_addr = 32'h80; m_req_ready = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (dut.state_q !== I_RESP) begin
      bad++;
      $display("FAIL rstmid_setup: got st=%b want %b", dut.state_q, I_RESP);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000BAD; i_rready = 1'b1;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    #1;
    total++;
    if (dut.state_q !== IDLE || i_rvalid !== 1'b0 || m_rready !== 1'b0 ||
        gnt_i_cnt !== 32'd0 || gnt_d_cnt !== 32'd0) begin
      bad++;
      $display("FAIL rstmid_abandon: got st=%b iv=%b mr=%b i=%0d d=%0d want %b 0 0 0 0",
               dut.state_q, i_rvalid, m_rready, gnt_i_cnt, gnt_d_cnt, IDLE);
    end
    @(negedge clk);
    #1;
    total++;
    if (dut.state_q !== IDLE || i_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after: got st=%b iv=%b want %b 0", dut.state_q, i_rvalid, IDLE);
    end
    m_rvalid = 1'b0; i_rready = 1'b0;
    $display("txn inst read addr=00000080 abandoned by reset");
  endtask

  task automatic test_cnt_wrap();
    @(negedge clk);
    force dut.gnt_d_cnt_d = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.gnt_d_cnt_d;
    #1;
    total++;
    if (gnt_d_cnt !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffffffff", gnt_d_cnt);
    end
    d_ren = 1'b1; d_addr = 32'h300; m_req_ready = 1'b1; d_rready = 1'b1;
    #1;
    total++;
    if (d_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_grant: got d_req_ready=%b want 1", d_req_ready);
    end
    @(negedge clk);
    d_ren = 1'b0;
    #1;
    total++;
    if (gnt_d_cnt !== 32'h0 || gnt_i_cnt !== exp_i_cnt) begin
      bad++;
      $display("FAIL wrap_count: got d=%h i=%h want 00000000 %h", gnt_d_cnt, gnt_i_cnt, exp_i_cnt);
    end
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h1;
    @(negedge clk);
    m_rvalid = 1'b0; d_rready = 1'b0;
    #1;
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL wrap_done: got st=%b want %b", dut.state_q, IDLE);
    end
    $display("txn data read addr=00000300 counter wrapped");
  endtask

`ifdef ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] want;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req_valid = 1'b1; i_addr = 32'h400; d_ren = 1'b1; d_addr = 32'h500;
    m_req_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77; i_rready = 1'b1; d_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      total++;
      if ({d_req_ready, i_req_ready} !== want) begin
        bad++;
        $display("FAIL rr_order%0d: got d,i=%b want %b", k, {d_req_ready, i_req_ready}, want);
      end
      $display("txn rr grant %0d to %s", k, (k % 2 == 0) ? "D" : "I");
      repeat (3) @(negedge clk);
    end
    i_req_valid = 1'b0; d_ren = 1'b0; m_rvalid = 1'b0;
    #1;
    total++;
    if (gnt_i_cnt !== 32'd2 || gnt_d_cnt !== 32'd2) begin
      bad++;
      $display("FAIL rr_counts: got i=%0d d=%0d want 2 2", gnt_i_cnt, gnt_d_cnt);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    i_addr = '0; i_req_valid = 1'b0; i_rready = 1'b0;
    d_addr = '0; d_wen = 1'b0; d_ren = 1'b0; d_wdata = '0; d_wstrb = '0; d_rready = 1'b0;
    m_req_ready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    exp_i_cnt = 0; exp_d_cnt = 0;
    test_reset();
    test_priority();
    test_write_stall();
    test_inst_backpressure();
    test_reset_midflight();
    test_cnt_wrap();
`ifdef ARB_RR_EN
    test_round_robin();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
